// File: rtl/lsu_pkg.sv
// Shared LSU definitions: width constants, memory-op encoding and the
// memory-access stage FSM states.
package lsu_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int LSU_OP_WIDTH   = 4;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [LSU_OP_WIDTH-1:0] {
        LSU_NONE = 4'd0,
        LSU_LB   = 4'd1,
        LSU_LH   = 4'd2,
        LSU_LW   = 4'd3,
        LSU_LBU  = 4'd4,
        LSU_LHU  = 4'd5,
        LSU_SB   = 4'd6,
        LSU_SH   = 4'd7,
        LSU_SW   = 4'd8
    } lsu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } mem_state_e;

    function automatic logic is_load(input lsu_op_e op);
        return (op == LSU_LB) || (op == LSU_LH) || (op == LSU_LW) ||
               (op == LSU_LBU) || (op == LSU_LHU);
    endfunction

    function automatic logic is_store(input lsu_op_e op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

endpackage

// File: rtl/load_align.sv
// Load-data lane select and sign/zero extension, driven by the op and the
// low address bits of the access.
module load_align
    import lsu_pkg::*;
(
    input  lsu_op_e                op,
    input  logic [1:0]             offset,
    input  logic [DATA_WIDTH-1:0]  rdata,
    output logic [DATA_WIDTH-1:0]  rw_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v  = rdata[{offset, 3'b000} +: 8];
        half_v  = offset[1] ? rdata[31:16] : rdata[15:0];
        rw_data = rdata;
        case (op)
            LSU_LB:  rw_data = {{24{byte_v[7]}}, byte_v};
            LSU_LBU: rw_data = {24'd0, byte_v};
            LSU_LH:  rw_data = {{16{half_v[15]}}, half_v};
            LSU_LHU: rw_data = {16'd0, half_v};
            default: rw_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: single-outstanding req/gnt/resp data bus,
// load extension, store lane steering; ALE detection under MEM_STAGE_ALE_CHECK_EN.
module mem_access_stage
    import lsu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_pc,
    input  logic [LSU_OP_WIDTH-1:0]   in_lsu_op,
    input  logic [DATA_WIDTH-1:0]     in_ex_result,
    input  logic [DATA_WIDTH-1:0]     in_lsu_data,
    input  logic                      in_rw_en,
    input  logic [REG_ADDR_WIDTH-1:0] in_rw_addr,
    output logic                      dreq,
    output logic                      dwe,
    output logic [DATA_WIDTH-1:0]     daddr,
    output logic [3:0]                dwstrb,
    output logic [DATA_WIDTH-1:0]     dwdata,
    input  logic                      dgnt,
    input  logic                      drvalid,
    input  logic [DATA_WIDTH-1:0]     drdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_pc,
    output logic                      out_rw_en,
    output logic [REG_ADDR_WIDTH-1:0] out_rw_addr,
    output logic [DATA_WIDTH-1:0]     out_rw_data,
    output logic                      out_ale,
    output logic [DATA_WIDTH-1:0]     out_badv
);

    mem_state_e            state;
    lsu_op_e               op_in;
    lsu_op_e               op_q;
    logic [1:0]            off_q;
    logic                  accept;
    logic                  in_mem;
    logic                  in_store;
    logic                  in_ale;
    logic [3:0]            strb_in;
    logic [DATA_WIDTH-1:0] wdata_in;
    logic [DATA_WIDTH-1:0] load_data;

    always_comb begin
        op_in    = lsu_op_e'(in_lsu_op);
        in_store = is_store(op_in);
        in_mem   = is_load(op_in) | in_store;
        in_ale   = 1'b0;
`ifdef MEM_STAGE_ALE_CHECK_EN
        case (op_in)
            LSU_LH, LSU_LHU, LSU_SH: in_ale = in_ex_result[0];
            LSU_LW, LSU_SW:          in_ale = |in_ex_result[1:0];
            default:                 in_ale = 1'b0;
        endcase
`endif
        strb_in  = '0;
        wdata_in = '0;
        case (op_in)
            LSU_SB: begin
                strb_in  = 4'b0001 << in_ex_result[1:0];
                wdata_in = {4{in_lsu_data[7:0]}};
            end
            LSU_SH: begin
                strb_in  = 4'b0011 << in_ex_result[1:0];
                wdata_in = {2{in_lsu_data[15:0]}};
            end
            LSU_SW: begin
                strb_in  = 4'b1111;
                wdata_in = in_lsu_data;
            end
            default: ;
        endcase
    end

    assign in_ready = (state == S_IDLE) | ((state == S_DONE) & out_ready);
    assign accept   = in_valid & in_ready & ~flush;

    load_align u_load_align (
        .op      (op_q),
        .offset  (off_q),
        .rdata   (drdata),
        .rw_data (load_data)
    );

    // Acceptance is handled ahead of the per-state cases; it can only fire
    // from IDLE or from DONE with out_ready, so both paths share one launch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            op_q        <= LSU_NONE;
            off_q       <= '0;
            dreq        <= 1'b0;
            dwe         <= 1'b0;
            daddr       <= '0;
            dwstrb      <= '0;
            dwdata      <= '0;
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_rw_en   <= 1'b0;
            out_rw_addr <= '0;
            out_rw_data <= '0;
            out_ale     <= 1'b0;
            out_badv    <= '0;
        end else if (accept) begin
            op_q        <= op_in;
            off_q       <= in_ex_result[1:0];
            out_pc      <= in_pc;
            out_rw_addr <= in_rw_addr;
            out_rw_data <= in_ex_result;
            out_rw_en   <= in_rw_en & ~in_store & ~in_ale;
            out_ale     <= in_ale;
            out_badv    <= in_ale ? in_ex_result : '0;
            if (in_mem && !in_ale) begin
                state     <= S_REQ;
                dreq      <= 1'b1;
                dwe       <= in_store;
                daddr     <= {in_ex_result[31:2], 2'b00};
                dwstrb    <= strb_in;
                dwdata    <= wdata_in;
                out_valid <= 1'b0;
            end else begin
                state     <= S_DONE;
                out_valid <= 1'b1;
            end
        end else begin
            case (state)
                S_IDLE: ;
                S_REQ: begin
                    if (dgnt) begin
                        dreq  <= 1'b0;
                        state <= flush ? S_DRAIN : S_WAIT;
                    end else if (flush) begin
                        dreq  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (drvalid) begin
                        if (flush) begin
                            state <= S_IDLE;
                        end else begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            if (is_load(op_q)) out_rw_data <= load_data;
                        end
                    end else if (flush) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: if (drvalid) state <= S_IDLE;
                S_DONE: begin
                    if (flush || out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table plus stall/flush sequences.
module tb_mem_access_stage;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [31:0] in_pc, in_ex_result, in_lsu_data;
    logic [3:0]  in_lsu_op;
    logic        in_rw_en;
    logic [4:0]  in_rw_addr;
    logic        dreq, dwe, dgnt, drvalid;
    logic [31:0] daddr, dwdata, drdata;
    logic [3:0]  dwstrb;
    logic        out_valid, out_ready, out_rw_en, out_ale;
    logic [31:0] out_pc, out_rw_data, out_badv;
    logic [4:0]  out_rw_addr;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_lsu_op(in_lsu_op), .in_ex_result(in_ex_result), .in_lsu_data(in_lsu_data),
        .in_rw_en(in_rw_en), .in_rw_addr(in_rw_addr),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwstrb(dwstrb), .dwdata(dwdata),
        .dgnt(dgnt), .drvalid(drvalid), .drdata(drdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rw_en(out_rw_en), .out_rw_addr(out_rw_addr), .out_rw_data(out_rw_data),
        .out_ale(out_ale), .out_badv(out_badv)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic        rw_en;
        logic [4:0]  rd;
        logic        exp_req;
        logic        exp_we;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rw_data;
        logic        exp_rw_en;
        logic        exp_ale;
        logic [31:0] exp_badv;
    } vec_t;

    vec_t vecs[12];
    vec_t extra;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive_in(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                            input logic rw_en, input logic [4:0] rd);
        in_valid     = 1'b1;
        in_lsu_op    = op;
        in_ex_result = addr;
        in_lsu_data  = sdata;
        in_rw_en     = rw_en;
        in_rw_addr   = rd;
        in_pc        = addr ^ 32'hFFFF_0000;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        @(negedge clk);
        out_ready = 1'b0;
        drive_in(v.op, v.addr, v.sdata, v.rw_en, v.rd);
        #1 chk({nm, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({nm, ".dreq"}, {31'd0, dreq}, {31'd0, v.exp_req});
        if (v.exp_req) begin
            chk({nm, ".daddr"}, daddr, {v.addr[31:2], 2'b00});
            chk({nm, ".dwe"}, {31'd0, dwe}, {31'd0, v.exp_we});
            chk({nm, ".dwstrb"}, {28'd0, dwstrb}, {28'd0, v.exp_strb});
            chk({nm, ".dwdata"}, dwdata, v.exp_wdata);
            chk({nm, ".early_valid"}, {31'd0, out_valid}, 32'd0);
            dgnt = 1'b1;
            @(negedge clk);
            dgnt = 1'b0;
            chk({nm, ".dreq_drop"}, {31'd0, dreq}, 32'd0);
            drvalid = 1'b1;
            drdata  = v.rdata;
            @(negedge clk);
            drvalid = 1'b0;
            drdata  = 32'h0;
        end
        chk({nm, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, ".rw_data"}, out_rw_data, v.exp_rw_data);
        chk({nm, ".rw_en"}, {31'd0, out_rw_en}, {31'd0, v.exp_rw_en});
        chk({nm, ".rw_addr"}, {27'd0, out_rw_addr}, {27'd0, v.rd});
        chk({nm, ".pc"}, out_pc, v.addr ^ 32'hFFFF_0000);
        chk({nm, ".ale"}, {31'd0, out_ale}, {31'd0, v.exp_ale});
        chk({nm, ".badv"}, out_badv, v.exp_badv);
        chk({nm, ".busy"}, {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, ".released"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //             op        addr          sdata         rdata         we rd  req we strb     wdata         rw_data       rwe ale badv
        vecs[0]  = '{LSU_NONE, 32'h0000_1234, 32'h0,        32'h0,        1, 5,  0, 0, 4'b0000, 32'h0,        32'h0000_1234, 1, 0, 32'h0};
        vecs[1]  = '{LSU_LB,   32'h0000_1003, 32'h0,        32'h80FF_FF00, 1, 6, 1, 0, 4'b0000, 32'h0,        32'hFFFF_FF80, 1, 0, 32'h0};
        vecs[2]  = '{LSU_LBU,  32'h0000_1003, 32'h0,        32'h80FF_FF00, 1, 7, 1, 0, 4'b0000, 32'h0,        32'h0000_0080, 1, 0, 32'h0};
        vecs[3]  = '{LSU_SH,   32'h0000_2002, 32'hABCD_5678, 32'h0,        1, 8, 1, 1, 4'b1100, 32'h5678_5678, 32'h0000_2002, 0, 0, 32'h0};
        vecs[4]  = '{LSU_LH,   32'h0000_4002, 32'h0,        32'h8001_7FFF, 1, 9, 1, 0, 4'b0000, 32'h0,        32'hFFFF_8001, 1, 0, 32'h0};
        vecs[5]  = '{LSU_LHU,  32'h0000_4002, 32'h0,        32'h8001_7FFF, 1, 10, 1, 0, 4'b0000, 32'h0,       32'h0000_8001, 1, 0, 32'h0};
        vecs[6]  = '{LSU_LW,   32'h0000_5000, 32'h0,        32'hDEAD_BEEF, 1, 11, 1, 0, 4'b0000, 32'h0,       32'hDEAD_BEEF, 1, 0, 32'h0};
        vecs[7]  = '{LSU_SB,   32'h0000_6001, 32'h0000_00A5, 32'h0,        1, 12, 1, 1, 4'b0010, 32'hA5A5_A5A5, 32'h0000_6001, 0, 0, 32'h0};
        vecs[8]  = '{LSU_SW,   32'h0000_7000, 32'h1122_3344, 32'h0,        0, 13, 1, 1, 4'b1111, 32'h1122_3344, 32'h0000_7000, 0, 0, 32'h0};
`ifdef MEM_STAGE_ALE_CHECK_EN
        vecs[9]  = '{LSU_LW,   32'h0000_3001, 32'h0,        32'hCAFE_F00D, 1, 14, 0, 0, 4'b0000, 32'h0,       32'h0000_3001, 0, 1, 32'h0000_3001};
        vecs[10] = '{LSU_SH,   32'h0000_2001, 32'h0000_BEEF, 32'h0,        1, 15, 0, 0, 4'b0000, 32'h0,       32'h0000_2001, 0, 1, 32'h0000_2001};
`else
        vecs[9]  = '{LSU_LW,   32'h0000_3001, 32'h0,        32'hCAFE_F00D, 1, 14, 1, 0, 4'b0000, 32'h0,       32'hCAFE_F00D, 1, 0, 32'h0};
        vecs[10] = '{LSU_SH,   32'h0000_2001, 32'h0000_BEEF, 32'h0,        1, 15, 1, 1, 4'b0110, 32'hBEEF_BEEF, 32'h0000_2001, 0, 0, 32'h0};
`endif
        vecs[11] = '{LSU_LB,   32'h0000_1000, 32'h0,        32'h1234_567F, 1, 16, 1, 0, 4'b0000, 32'h0,       32'h0000_007F, 1, 0, 32'h0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_lsu_op = '0; in_ex_result = '0; in_lsu_data = '0;
        in_rw_en = 1'b0; in_rw_addr = '0; dgnt = 1'b0; drvalid = 1'b0; drdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset.dreq", {31'd0, dreq}, 32'd0);
        chk("reset.rw_data", out_rw_data, 32'd0);
        chk("reset.daddr", daddr, 32'd0);
        chk("reset.in_ready", {31'd0, in_ready}, 32'd1);

        for (int unsigned i = 0; i < 12; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Grant stall, then result stall, then back-to-back accept.
        @(negedge clk);
        drive_in(LSU_LW, 32'h0000_8000, 32'h0, 1'b1, 5'd3);
        @(negedge clk);
        in_valid = 1'b0;
        for (int unsigned c = 0; c < 4; c++) begin
            chk($sformatf("stall%0d.dreq", c), {31'd0, dreq}, 32'd1);
            chk($sformatf("stall%0d.daddr", c), daddr, 32'h0000_8000);
            @(negedge clk);
        end
        dgnt = 1'b1;
        @(negedge clk);
        dgnt = 1'b0; drvalid = 1'b1; drdata = 32'h2468_ACE0;
        @(negedge clk);
        drvalid = 1'b0; drdata = 32'h0;
        for (int unsigned c = 0; c < 3; c++) begin
            chk($sformatf("hold%0d.out_valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("hold%0d.rw_data", c), out_rw_data, 32'h2468_ACE0);
            chk($sformatf("hold%0d.in_ready", c), {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drive_in(LSU_LW, 32'h0000_9004, 32'h0, 1'b1, 5'd4);
        #1 chk("b2b.in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b.dreq", {31'd0, dreq}, 32'd1);
        chk("b2b.daddr", daddr, 32'h0000_9004);
        chk("b2b.out_valid", {31'd0, out_valid}, 32'd0);
        dgnt = 1'b1;
        @(negedge clk);
        dgnt = 1'b0; drvalid = 1'b1; drdata = 32'h1357_9BDF;
        @(negedge clk);
        drvalid = 1'b0;
        chk("b2b.rw_data", out_rw_data, 32'h1357_9BDF);
        chk("b2b.rw_addr", {27'd0, out_rw_addr}, 32'd4);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Flush while waiting for the response; response arrives two cycles later.
        drive_in(LSU_LW, 32'h0000_A000, 32'h0, 1'b1, 5'd2);
        @(negedge clk);
        in_valid = 1'b0;
        dgnt = 1'b1;
        @(negedge clk);
        dgnt = 1'b0;
        flush = 1'b1;
        chk("flush.wait_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush.drain_ready", {31'd0, in_ready}, 32'd0);
        chk("flush.drain_valid", {31'd0, out_valid}, 32'd0);
        drvalid = 1'b1; drdata = 32'hFFFF_FFFF;
        @(negedge clk);
        drvalid = 1'b0; drdata = 32'h0;
        chk("flush.after_ready", {31'd0, in_ready}, 32'd1);
        chk("flush.after_valid", {31'd0, out_valid}, 32'd0);
        extra = '{LSU_LB, 32'h0000_B002, 32'h0, 32'h0055_0000, 1, 17, 1, 0, 4'b0000, 32'h0,
                  32'h0000_0055, 1, 0, 32'h0};
        run_vec(extra, "post_flush");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
